div_result_bcd: RTL and testbench

Sequential binary-to-BCD formatter sitting directly downstream of the 8-bit combinational divider. It captures one quotient/remainder pair through a valid/ready handshake and converts both values to 3-digit packed BCD in parallel, using iterative double-dabble (add-3 then shift), one bit per cycle. It presents the decimal result to the display/report stage with a valid/ready handshake and holds it under backpressure.

---
 rtl/div_pkg.sv | 16 +
 rtl/bcd_dabble_step.sv | 26 ++
 rtl/div_result_bcd.sv | 101 ++++++++++
 tb/tb_div_result_bcd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the divider result BCD formatter.
package div_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned NDIG        = 3;
    localparam int unsigned DIG_W       = 4;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned CNT_W       = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: add-3 to each digit >= 5, then shift {digits, bin} left by one.
module bcd_dabble_step #(
    parameter int unsigned DATA_W = div_pkg::DATA_W,
    parameter int unsigned NDIG   = div_pkg::NDIG
) (
    input  logic [4*NDIG-1:0] digits,
    input  logic [DATA_W-1:0] bin,
    output logic [4*NDIG-1:0] digits_nxt,
    output logic [DATA_W-1:0] bin_nxt
);
    import div_pkg::*;

    logic [4*NDIG-1:0] adj;

    // Per-digit 4-bit add-3 (no inter-digit carry), then the 1-bit shift moves the MSBs up.
    always_comb begin
        adj = digits;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (digits[i*DIG_W +: DIG_W] >= DIG_W'(ADD3_THRESH)) begin
                adj[i*DIG_W +: DIG_W] = digits[i*DIG_W +: DIG_W] + DIG_W'(3);
            end
        end
        {digits_nxt, bin_nxt} = {adj[4*NDIG-2:0], bin, 1'b0};
    end

endmodule

// File: rtl/div_result_bcd.sv
// Captures a divider quotient/remainder pair and converts both to packed BCD, one bit per cycle.
module div_result_bcd #(
    parameter int unsigned DATA_W = div_pkg::DATA_W,
    parameter int unsigned NDIG   = div_pkg::NDIG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   quot,
    input  logic [DATA_W-1:0]   rem,
    input  logic                in_div0,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   quot_bcd,
    output logic [4*NDIG-1:0]   rem_bcd,
    output logic                out_div0
);
    import div_pkg::*;

    localparam int unsigned STEP_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e                  state;
    logic [STEP_CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]       q_bin;
    logic [DATA_W-1:0]       r_bin;
    logic [4*NDIG-1:0]       q_dig_nxt;
    logic [4*NDIG-1:0]       r_dig_nxt;
    logic [DATA_W-1:0]       q_bin_nxt;
    logic [DATA_W-1:0]       r_bin_nxt;

    bcd_dabble_step #(.DATA_W(DATA_W), .NDIG(NDIG)) u_step_quot (
        .digits     (quot_bcd),
        .bin        (q_bin),
        .digits_nxt (q_dig_nxt),
        .bin_nxt    (q_bin_nxt)
    );

    bcd_dabble_step #(.DATA_W(DATA_W), .NDIG(NDIG)) u_step_rem (
        .digits     (rem_bcd),
        .bin        (r_bin),
        .digits_nxt (r_dig_nxt),
        .bin_nxt    (r_bin_nxt)
    );

    // Handshake FSM, step counter and result registers; in_ready/out_valid track state only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot_bcd  <= '0;
            rem_bcd   <= '0;
            out_div0  <= 1'b0;
            q_bin     <= '0;
            r_bin     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_bin    <= quot;
                        r_bin    <= rem;
                        quot_bcd <= '0;
                        rem_bcd  <= '0;
                        out_div0 <= in_div0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    quot_bcd <= q_dig_nxt;
                    rem_bcd  <= r_dig_nxt;
                    q_bin    <= q_bin_nxt;
                    r_bin    <= r_bin_nxt;
                    cnt      <= cnt + STEP_CNT_W'(1);
                    if (cnt == STEP_CNT_W'(DATA_W - 1)) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed scenarios plus randomized transactions.
module tb_div_result_bcd;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NDIG   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       quot;
    logic [7:0]       rem;
    logic             in_div0;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      quot_bcd;
    logic [11:0]      rem_bcd;
    logic             out_div0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    div_result_bcd #(.DATA_W(DATA_W), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quot      (quot),
        .rem       (rem),
        .in_div0   (in_div0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot_bcd  (quot_bcd),
        .rem_bcd   (rem_bcd),
        .out_div0  (out_div0)
    );

    // Decimal reference: hundreds, tens, units digits packed as BCD.
    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic send(input logic [7:0] q, input logic [7:0] r, input logic d, output int lat);
        int n;
        quot     = q;
        rem      = r;
        in_div0  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] q, input logic [7:0] r, input logic d);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_quot"}, quot_bcd, to_bcd(q));
        check({tag, "_rem"}, rem_bcd, to_bcd(r));
        check({tag, "_div0"}, out_div0, d);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int n;
        int acc[3];
        logic [7:0] b2b[3];
        logic seen;
        logic [7:0] q, r;
        logic d;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quot      = '0;
        rem       = '0;
        in_div0   = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid", out_valid, 0);
            check("rst_quot", quot_bcd, 0);
            check("rst_rem", rem_bcd, 0);
            check("rst_div0", out_div0, 0);
            check("rst_ready", in_ready, 1);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);

        // Maximum values.
        send(8'hFF, 8'h0E, 1'b0, lat);
        check("max_latency", lat, DATA_W);
        expect_result("max", 8'hFF, 8'h0E, 1'b0);
        check("max_quot_const", quot_bcd, 12'h255);
        check("max_rem_const", rem_bcd, 12'h014);
        release_out("max");

        // Zero with div0 flag.
        send(8'h00, 8'h00, 1'b1, lat);
        check("zero_latency", lat, DATA_W);
        expect_result("zero", 8'h00, 8'h00, 1'b1);
        release_out("zero");

        // Backpressure with a competing request.
        send(8'h64, 8'h09, 1'b0, lat);
        check("bp_latency", lat, DATA_W);
        expect_result("bp", 8'h64, 8'h09, 1'b0);
        quot     = 8'h33;
        rem      = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_quot", quot_bcd, 12'h100);
            check("bp_hold_rem", rem_bcd, 12'h009);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_ready", in_ready, 1);
        check("bp_idle_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("bp_new_accepted", in_ready, 0);
        wait_out(lat);
        check("bp_new_latency", lat, DATA_W);
        expect_result("bp_new", 8'h33, 8'h01, 1'b0);
        release_out("bp_new");

        // Reset in the middle of a conversion.
        quot     = 8'h77;
        rem      = 8'h05;
        in_div0  = 1'b1;
        in_valid = 1'b1;
        check("mid_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_div0", out_div0, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_output", seen, 0);
        send(8'h2A, 8'h07, 1'b0, lat);
        check("mid_next_latency", lat, DATA_W);
        expect_result("mid_next", 8'h2A, 8'h07, 1'b0);
        release_out("mid_next");

        // Back-to-back with in_valid and out_ready held high.
        b2b[0] = 8'h0A;
        b2b[1] = 8'h63;
        b2b[2] = 8'hC8;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_div0   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            quot = b2b[i];
            rem  = 8'(i + 1);
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            acc[i] = cyc;
            tick();
            if (i == 2) in_valid = 1'b0;
            wait_out(lat);
            expect_result("b2b", b2b[i], 8'(i + 1), 1'b0);
        end
        check("b2b_q0_const", to_bcd(b2b[0]), 12'h010);
        check("b2b_spacing_1", acc[1] - acc[0], DATA_W + 2);
        check("b2b_spacing_2", acc[2] - acc[1], DATA_W + 2);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("b2b_end_ready", in_ready, 1);

        // Randomized transactions with random backpressure.
        for (int t = 0; t < 30; t++) begin
            q = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            d = 1'($urandom_range(0, 1));
            send(q, r, d, lat);
            check("rand_latency", lat, DATA_W);
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) tick();
            expect_result("rand", q, r, d);
            release_out("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
